serial_word_deserializer: RTL and testbench

Serial-in, parallel-out stage sitting directly downstream of the select-gated D flip-flop capture cell. It consumes the captured serial bit plus its load strobe, assembles WIDTH bits into a word, and presents the word on a valid/ready output port. It also tracks partial-word progress and flags overruns when the consumer stalls.

---
 rtl/serial_word_deserializer_pkg.sv | 8 +
 rtl/sipo_shift_reg.sv | 47 ++++
 rtl/serial_word_deserializer.sv | 98 +++++++++
 tb/tb_serial_word_deserializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_deserializer_pkg.sv
// Shared constants for the serial word deserializer: default word width and bit-order encodings.
package serial_word_deserializer_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam bit MSB_FIRST_ORDER = 1'b1;
    localparam bit LSB_FIRST_ORDER = 1'b0;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in shift register holding the WIDTH-1 bits already received; word_next is the
// full word that would exist if bit_in were shifted in now. Cleared by reset or clear.
module sipo_shift_reg
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_next
);

    // The oldest bit of a full-width register would always be shifted out before it is
    // ever part of a word, so only WIDTH-1 bits need storing.
    logic [WIDTH-2:0] partial_q;
    logic [WIDTH-2:0] partial_d;

    always_comb begin
        if (MSB_FIRST) begin
            word_next = {partial_q, bit_in};
        end else begin
            word_next = {bit_in, partial_q};
        end
    end

    always_comb begin
        partial_d = partial_q;
        if (clear) begin
            partial_d = '0;
        end else if (shift_en) begin
            partial_d = MSB_FIRST ? word_next[WIDTH-2:0] : word_next[WIDTH-1:1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            partial_q <= '0;
        end else begin
            partial_q <= partial_d;
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Assembles WIDTH strobed serial bits into a word and holds it on a valid/ready port.
// One cycle from final-bit edge to word_valid; a word completing while the slot is stalled is dropped and flagged.
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic [WIDTH-1:0] word_out_q, word_out_d;
    logic             word_valid_q, word_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] word_next;
    logic             shift_en;
    logic             last_bit;
    logic             word_done;
    logic             slot_free;

    assign shift_en  = bit_valid && !clear;
    assign last_bit  = (bit_count_q == CNT_W'(WIDTH - 1));
    assign word_done = shift_en && last_bit;
    // A draining word frees the slot in the same edge the new word lands.
    assign slot_free = !word_valid_q || word_ready;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (clear),
        .bit_in    (bit_in),
        .word_next (word_next)
    );

    always_comb begin
        bit_count_d  = bit_count_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        overrun_d    = overrun_q;

        if (clear) begin
            bit_count_d = '0;
            overrun_d   = 1'b0;
        end else if (bit_valid) begin
            bit_count_d = last_bit ? '0 : bit_count_q + CNT_W'(1);
        end

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (word_done) begin
            if (slot_free) begin
                word_out_d   = word_next;
                word_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_count_q  <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bit_count_q  <= bit_count_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign bit_count  = bit_count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: an MSB-first and an LSB-first instance share stimulus.
module tb_serial_word_deserializer;

    logic       clock;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       word_ready;

    logic [7:0] wo_m, wo_l;
    logic       wv_m, wv_l;
    logic [2:0] bc_m, bc_l;
    logic       ov_m, ov_l;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .word_out   (wo_m),
        .word_valid (wv_m),
        .word_ready (word_ready),
        .bit_count  (bc_m),
        .overrun    (ov_m)
    );

    serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .word_out   (wo_l),
        .word_valid (wv_l),
        .word_ready (word_ready),
        .bit_count  (bc_l),
        .overrun    (ov_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Scoreboard: a transfer happens on the next rising edge when valid && ready here.
    always @(negedge clock) begin
        if (!reset && word_ready) begin
            if (wv_m) begin
                if (q_m.size() == 0) chk("sb_msb_unexpected", {24'd0, wo_m}, 32'hFFFF_FFFF);
                else chk("sb_msb_word", {24'd0, wo_m}, {24'd0, q_m.pop_front()});
            end
            if (wv_l) begin
                if (q_l.size() == 0) chk("sb_lsb_unexpected", {24'd0, wo_l}, 32'hFFFF_FFFF);
                else chk("sb_lsb_word", {24'd0, wo_l}, {24'd0, q_l.pop_front()});
            end
        end
    end

    task automatic step(input logic bv, input logic bi, input logic clr);
        bit_valid = bv;
        bit_in    = bi;
        clear     = clr;
        @(posedge clock);
        #1;
        bit_valid = 1'b0;
        clear     = 1'b0;
    endtask

    // Sends the first n bits of w starting from w[7].
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[7-i], 1'b0);
    endtask

    task automatic push_word(input logic [7:0] w);
        q_m.push_back(w);
        q_l.push_back(rev8(w));
    endtask

    typedef struct {
        logic       bv;
        logic       bi;
        logic       ev;
        logic [2:0] ec;
        logic [7:0] ew_m;
        logic [7:0] ew_l;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0] pat;
        int         gaps;

        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            tbl[i].bv   = 1'b1;
            tbl[i].bi   = pat[7-i];
            tbl[i].ev   = (i == 7);
            tbl[i].ec   = 3'((i + 1) % 8);
            tbl[i].ew_m = (i == 7) ? 8'hB2 : 8'h00;
            tbl[i].ew_l = (i == 7) ? 8'h4D : 8'h00;
        end
        tbl[8].bv   = 1'b0;
        tbl[8].bi   = 1'b0;
        tbl[8].ev   = 1'b0;
        tbl[8].ec   = 3'd0;
        tbl[8].ew_m = 8'hB2;
        tbl[8].ew_l = 8'h4D;

        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b1;
        #12 reset  = 1'b0;

        chk("reset_word_out", {24'd0, wo_m}, 32'h0);
        chk("reset_word_valid", {31'd0, wv_m}, 32'h0);
        chk("reset_bit_count", {29'd0, bc_m}, 32'h0);
        chk("reset_overrun", {31'd0, ov_m}, 32'h0);

        // Back-to-back bits, consumer always ready.
        push_word(8'hB2);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].bv, tbl[i].bi, 1'b0);
            chk($sformatf("t1_valid[%0d]", i), {31'd0, wv_m}, {31'd0, tbl[i].ev});
            chk($sformatf("t1_count[%0d]", i), {29'd0, bc_m}, {29'd0, tbl[i].ec});
            chk($sformatf("t1_word_m[%0d]", i), {24'd0, wo_m}, {24'd0, tbl[i].ew_m});
            chk($sformatf("t1_word_l[%0d]", i), {24'd0, wo_l}, {24'd0, tbl[i].ew_l});
            chk($sformatf("t1_overrun[%0d]", i), {31'd0, ov_m}, 32'h0);
        end

        // Same bits with random strobe gaps.
        push_word(8'hB2);
        for (int i = 0; i < 8; i++) begin
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, 1'b1, 1'b0);
                chk("t2_gap_count", {29'd0, bc_l}, i);
            end
            step(1'b1, pat[7-i], 1'b0);
            chk("t2_count", {29'd0, bc_l}, (i + 1) % 8);
        end
        chk("t2_valid_l", {31'd0, wv_l}, 32'h1);
        chk("t2_word_l", {24'd0, wo_l}, 32'h4D);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_drained", {31'd0, wv_l}, 32'h0);

        // Stalled consumer: second word is dropped and flagged.
        word_ready = 1'b0;
        push_word(8'hB2);
        send_bits(8'hB2, 8);
        chk("t3_first_valid", {31'd0, wv_m}, 32'h1);
        chk("t3_no_overrun_yet", {31'd0, ov_m}, 32'h0);
        send_bits(8'h5A, 8);
        chk("t3_word_held_m", {24'd0, wo_m}, 32'hB2);
        chk("t3_word_held_l", {24'd0, wo_l}, 32'h4D);
        chk("t3_valid_held", {31'd0, wv_m}, 32'h1);
        chk("t3_overrun_m", {31'd0, ov_m}, 32'h1);
        chk("t3_overrun_l", {31'd0, ov_l}, 32'h1);
        word_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        word_ready = 1'b0;
        chk("t3_drain_valid", {31'd0, wv_m}, 32'h0);
        chk("t3_overrun_sticky", {31'd0, ov_m}, 32'h1);
        chk("t3_word_kept", {24'd0, wo_m}, 32'hB2);

        // Clear the flag, then drain and complete on the same edge.
        step(1'b0, 1'b0, 1'b1);
        chk("t4_clear_overrun", {31'd0, ov_m}, 32'h0);
        push_word(8'h11);
        send_bits(8'h11, 8);
        chk("t4_hold_word", {24'd0, wo_m}, 32'h11);
        chk("t4_hold_valid", {31'd0, wv_m}, 32'h1);
        push_word(8'h22);
        send_bits(8'h22, 7);
        word_ready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("t4_swap_word_m", {24'd0, wo_m}, 32'h22);
        chk("t4_swap_word_l", {24'd0, wo_l}, 32'h44);
        chk("t4_swap_valid", {31'd0, wv_m}, 32'h1);
        chk("t4_swap_overrun", {31'd0, ov_m}, 32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_drained", {31'd0, wv_m}, 32'h0);

        // Clear mid-word with a coincident strobe.
        send_bits(8'hFF, 5);
        chk("t5_partial_count", {29'd0, bc_m}, 32'h5);
        step(1'b1, 1'b1, 1'b1);
        chk("t5_cleared_count", {29'd0, bc_m}, 32'h0);
        push_word(8'hC3);
        send_bits(8'hC3, 8);
        chk("t5_word_m", {24'd0, wo_m}, 32'hC3);
        chk("t5_word_l", {24'd0, wo_l}, 32'hC3);
        chk("t5_valid", {31'd0, wv_m}, 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-word with a held word and overrun set.
        word_ready = 1'b0;
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 8);
        send_bits(8'h96, 3);
        chk("t6_pre_valid", {31'd0, wv_m}, 32'h1);
        chk("t6_pre_overrun", {31'd0, ov_m}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_word_m", {24'd0, wo_m}, 32'h0);
        chk("t6_rst_word_l", {24'd0, wo_l}, 32'h0);
        chk("t6_rst_valid", {31'd0, wv_m}, 32'h0);
        chk("t6_rst_count", {29'd0, bc_m}, 32'h0);
        chk("t6_rst_overrun", {31'd0, ov_m}, 32'h0);
        @(posedge clock);
        #2 reset = 1'b0;
        word_ready = 1'b1;
        push_word(8'h96);
        send_bits(8'h96, 8);
        chk("t6_word_m", {24'd0, wo_m}, 32'h96);
        chk("t6_word_l", {24'd0, wo_l}, 32'h69);
        chk("t6_valid", {31'd0, wv_m}, 32'h1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        chk("sb_msb_empty", q_m.size(), 32'h0);
        chk("sb_lsb_empty", q_l.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
